// File: rtl/md_unit_if.sv
// Operand/result bundle between the E-stage datapath and the multiply/divide unit.
// The master drives the operation request; the slave returns busy and HI/LO.
interface md_unit_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, req, input busy, hi, lo);
    modport slave  (input start, op, a, b, req, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: results are computed at acceptance into shadow registers,
// then committed to HI/LO after a fixed latency while busy holds off dependent instructions.
module md_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input logic      clk,
    input logic      reset_n,
    md_unit_if.slave md
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    logic [31:0] hi_r, lo_r, hi_s, lo_s;
    logic        busy_r;
    logic [3:0]  cnt;
    logic        accept;
    logic [63:0] mul_s_res, mul_u_res, div_s_res, div_u_res;

    function automatic logic [63:0] mul_signed(input logic signed [31:0] x, input logic signed [31:0] y);
        logic signed [63:0] xs, ys;
        xs = {{32{x[31]}}, x};
        ys = {{32{y[31]}}, y};
        return 64'(xs * ys);
    endfunction

    function automatic logic [63:0] mul_unsigned(input logic [31:0] x, input logic [31:0] y);
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Divide magnitudes, then restore signs; this also yields 0x80000000 / -1 = 0x80000000 rem 0.
    function automatic logic [63:0] div_signed(input logic signed [31:0] x, input logic signed [31:0] y);
        logic [31:0] ux, uy, uq, ur;
        ux = x[31] ? 32'(-x) : 32'(x);
        uy = y[31] ? 32'(-y) : 32'(y);
        uq = ux / uy;
        ur = ux % uy;
        if (x[31] ^ y[31]) uq = 32'(-uq);
        if (x[31])         ur = 32'(-ur);
        return {ur, uq};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] x, input logic [31:0] y);
        return {x % y, x / y};
    endfunction

    assign accept    = md.start && !md.req && !busy_r && (md.op >= OP_MULT) && (md.op <= OP_MTLO);
    assign mul_s_res = mul_signed(md.a, md.b);
    assign mul_u_res = mul_unsigned(md.a, md.b);
    assign div_s_res = div_signed(md.a, md.b);
    assign div_u_res = div_unsigned(md.a, md.b);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            hi_s   <= 32'd0;
            lo_s   <= 32'd0;
            busy_r <= 1'b0;
            cnt    <= 4'd0;
        end else if (busy_r) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                hi_r   <= hi_s;
                lo_r   <= lo_s;
                busy_r <= 1'b0;
            end
        end else if (accept) begin
            unique case (md.op)
                OP_MULT, OP_MULTU: begin
                    {hi_s, lo_s} <= (md.op == OP_MULT) ? mul_s_res : mul_u_res;
                    cnt          <= 4'(MUL_LAT);
                    busy_r       <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    // Divide by zero replays the current HI/LO so the commit leaves them untouched.
                    if (md.b == 32'd0) begin
                        hi_s <= hi_r;
                        lo_s <= lo_r;
                    end else begin
                        {hi_s, lo_s} <= (md.op == OP_DIV) ? div_s_res : div_u_res;
                    end
                    cnt    <= 4'(DIV_LAT);
                    busy_r <= 1'b1;
                end
                OP_MTHI: hi_r <= md.a;
                OP_MTLO: lo_r <= md.a;
                default: ;
            endcase
        end
    end

    assign md.busy = busy_r;
    assign md.hi   = hi_r;
    assign md.lo   = lo_r;
endmodule
